// File: rtl/csr_pkg.sv
// csr_pkg: shared CSR addresses, bit positions, cause codes and trap FSM states
// Imported by irq_prio_sel and csr_trap_ctrl; no ports.
package csr_pkg;
    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MIP     = 12'h344;
    localparam int BIT_MIE  = 3;
    localparam int BIT_MPIE = 7;
    localparam int BIT_MTIE = 7;
    localparam int BIT_MEIE = 11;
    localparam int CODE_EXT = 11;
    localparam int CODE_TMR = 7;
    localparam logic [31:0] CAUSE_EXT = 32'h8000000B;
    localparam logic [31:0] CAUSE_TMR = 32'h80000007;
    typedef enum logic [3:0] {
        IDLE, WAIT_ACK, RD_MST, RD_MIE, WR_MEPC, WR_MCAUSE, WR_MST, RD_MTVEC, REDIR,
        MRET_RD_MST, MRET_WR_MST, MRET_RD_EPC, MRET_REDIR
    } trap_state_e;
endpackage

// File: rtl/csr_trap_ctrl_if.sv
// csr_trap_ctrl_if: CSR register-file access port plus trap-in-progress flag
// master (trap controller): drives addr/we/re/wdata/intr, samples rdata
// slave (CSR file): samples addr/we/re/wdata/intr, drives combinational rdata; writes land on negedge
interface csr_trap_ctrl_if #(parameter int DW = 32, parameter int ADDRW = 12);
    logic [ADDRW-1:0] addr;
    logic             we;
    logic             re;
    logic             intr;
    logic [DW-1:0]    wdata;
    logic [DW-1:0]    rdata;
    modport master(output addr, we, re, wdata, intr, input rdata);
    modport slave(input addr, we, re, wdata, intr, output rdata);
endinterface

// File: rtl/irq_prio_sel.sv
// irq_prio_sel: fixed-priority interrupt select, external over timer
// in : ext_irq_i, tmr_irq_i
// out: pending_o (any irq), ext_sel_o (external chosen), cause_o (mcause value),
//      en_idx_o (mie enable bit for the chosen source)
module irq_prio_sel
    import csr_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic                  ext_irq_i,
    input  logic                  tmr_irq_i,
    output logic                  pending_o,
    output logic                  ext_sel_o,
    output logic [DW-1:0]         cause_o,
    output logic [$clog2(DW)-1:0] en_idx_o
);
    localparam int IW = $clog2(DW);
    always_comb begin
        pending_o = ext_irq_i | tmr_irq_i;
        ext_sel_o = ext_irq_i;
        cause_o   = {1'b1, (DW-1)'(ext_irq_i ? CODE_EXT : CODE_TMR)};
        en_idx_o  = ext_irq_i ? IW'(BIT_MEIE) : IW'(BIT_MTIE);
    end
endmodule

// File: rtl/csr_trap_ctrl.sv
// csr_trap_ctrl: machine-mode trap/mret sequencer driving the CSR file port
// in : clk_i, rst_i (async, active-high), ext_irq_i, tmr_irq_i, mret_i, stall_ack_i, pc_i
// out: stall_o, busy_o, redir_valid_o, redir_pc_o
// csr: master side of csr_trap_ctrl_if (addr/we/re/wdata/intr out, rdata in)
// Optional: define CSR_TRAP_VECTORED_EN to honour mtvec vectored mode (01).
module csr_trap_ctrl
    import csr_pkg::*;
#(
    parameter int DW    = 32,
    parameter int ADDRW = 12
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  ext_irq_i,
    input  logic                  tmr_irq_i,
    input  logic                  mret_i,
    input  logic                  stall_ack_i,
    input  logic [DW-1:0]         pc_i,
    csr_trap_ctrl_if.master       csr,
    output logic                  stall_o,
    output logic                  busy_o,
    output logic                  redir_valid_o,
    output logic [DW-1:0]         redir_pc_o
);
    localparam int IW = $clog2(DW);
    trap_state_e   state_q, state_d;
    logic          pend, sel_ext, ext_q;
    logic [DW-1:0] sel_cause, cause_q, mst_q, tgt_q, base, vec_tgt;
    logic [IW-1:0] sel_idx, en_q;
    irq_prio_sel #(.DW(DW)) u_sel (
        .ext_irq_i(ext_irq_i),
        .tmr_irq_i(tmr_irq_i),
        .pending_o(pend),
        .ext_sel_o(sel_ext),
        .cause_o  (sel_cause),
        .en_idx_o (sel_idx)
    );
    assign base = {csr.rdata[DW-1:2], 2'b00};
`ifdef CSR_TRAP_VECTORED_EN
    assign vec_tgt = (csr.rdata[1:0] == 2'b01) ? base + {cause_q[DW-3:0], 2'b00} : base;
`else
    assign vec_tgt = base;
`endif
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cause_q <= '0;
            ext_q   <= 1'b0;
            en_q    <= '0;
            mst_q   <= '0;
            tgt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && state_d == WAIT_ACK) begin
                cause_q <= sel_cause;
                ext_q   <= sel_ext;
                en_q    <= sel_idx;
            end
            if (state_q == RD_MST || state_q == MRET_RD_MST) mst_q <= csr.rdata;
            if (state_q == RD_MTVEC) tgt_q <= vec_tgt;
            if (state_q == MRET_RD_EPC) tgt_q <= csr.rdata;
        end
    end
    always_comb begin
        state_d       = state_q;
        csr.addr      = '0;
        csr.we        = 1'b0;
        csr.re        = 1'b0;
        csr.wdata     = '0;
        csr.intr      = 1'b0;
        redir_valid_o = 1'b0;
        redir_pc_o    = '0;
        stall_o       = state_q != IDLE;
        busy_o        = state_q != IDLE;
        unique case (state_q)
            IDLE: state_d = mret_i ? MRET_RD_MST : pend ? WAIT_ACK : IDLE;
            // only the source that was latched may keep the request alive
            WAIT_ACK: state_d = !(ext_q ? ext_irq_i : tmr_irq_i) ? IDLE : stall_ack_i ? RD_MST : WAIT_ACK;
            RD_MST: begin
                csr.re   = 1'b1;
                csr.addr = ADDRW'(CSR_MSTATUS);
                state_d  = csr.rdata[BIT_MIE] ? RD_MIE : IDLE;
            end
            RD_MIE: begin
                csr.re   = 1'b1;
                csr.addr = ADDRW'(CSR_MIE);
                state_d  = csr.rdata[en_q] ? WR_MEPC : IDLE;
            end
            WR_MEPC: begin
                csr.we    = 1'b1;
                csr.intr  = 1'b1;
                csr.addr  = ADDRW'(CSR_MEPC);
                csr.wdata = pc_i;
                state_d   = WR_MCAUSE;
            end
            WR_MCAUSE: begin
                csr.we    = 1'b1;
                csr.intr  = 1'b1;
                csr.addr  = ADDRW'(CSR_MCAUSE);
                csr.wdata = cause_q;
                state_d   = WR_MST;
            end
            WR_MST: begin
                csr.we                = 1'b1;
                csr.intr              = 1'b1;
                csr.addr              = ADDRW'(CSR_MSTATUS);
                csr.wdata             = mst_q;
                csr.wdata[BIT_MPIE]   = mst_q[BIT_MIE];
                csr.wdata[BIT_MIE]    = 1'b0;
                state_d               = RD_MTVEC;
            end
            RD_MTVEC: begin
                csr.re   = 1'b1;
                csr.intr = 1'b1;
                csr.addr = ADDRW'(CSR_MTVEC);
                state_d  = REDIR;
            end
            REDIR: begin
                csr.intr      = 1'b1;
                redir_valid_o = 1'b1;
                redir_pc_o    = tgt_q;
                state_d       = IDLE;
            end
            MRET_RD_MST: begin
                csr.re   = 1'b1;
                csr.addr = ADDRW'(CSR_MSTATUS);
                state_d  = MRET_WR_MST;
            end
            MRET_WR_MST: begin
                csr.we              = 1'b1;
                csr.addr            = ADDRW'(CSR_MSTATUS);
                csr.wdata           = mst_q;
                csr.wdata[BIT_MIE]  = mst_q[BIT_MPIE];
                csr.wdata[BIT_MPIE] = 1'b1;
                state_d             = MRET_RD_EPC;
            end
            MRET_RD_EPC: begin
                csr.re   = 1'b1;
                csr.addr = ADDRW'(CSR_MEPC);
                state_d  = MRET_REDIR;
            end
            MRET_REDIR: begin
                redir_valid_o = 1'b1;
                redir_pc_o    = tgt_q;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_csr_trap_ctrl.sv
// tb_csr_trap_ctrl: directed bench with a CSR-file model and a redirect scoreboard
module tb_csr_trap_ctrl;
    import csr_pkg::*;
    typedef struct {
        logic [31:0] pc;
        int          cyc;
    } exp_t;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        ext = 1'b0, tmr = 1'b0, mret = 1'b0, ack = 1'b0;
    logic [31:0] pc = '0;
    logic        stall, busy, rv;
    logic [31:0] rpc;
    logic [31:0] mstatus = '0, mie = '0, mtvec = '0, mepc = '0, mcause = '0;
    logic        ld = 1'b0;
    logic [31:0] ld_mst = '0, ld_mie = '0, ld_mtvec = '0;
    int          cyc = 0, wr_cnt = 0, rd300 = 0, rdoth = 0, redir_cnt = 0;
    int          npass = 0, ntot = 0;
    exp_t        sb[$];
    csr_trap_ctrl_if bus ();
    always #5 clk_i = ~clk_i;
    csr_trap_ctrl u_dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .ext_irq_i    (ext),
        .tmr_irq_i    (tmr),
        .mret_i       (mret),
        .stall_ack_i  (ack),
        .pc_i         (pc),
        .csr          (bus),
        .stall_o      (stall),
        .busy_o       (busy),
        .redir_valid_o(rv),
        .redir_pc_o   (rpc)
    );
    always_comb begin
        bus.rdata = '0;
        if (bus.re)
            case (bus.addr)
                CSR_MSTATUS: bus.rdata = mstatus;
                CSR_MIE:     bus.rdata = mie;
                CSR_MTVEC:   bus.rdata = mtvec;
                CSR_MEPC:    bus.rdata = mepc;
                CSR_MCAUSE:  bus.rdata = mcause;
                default:     bus.rdata = '0;
            endcase
    end
    always @(negedge clk_i) begin
        if (ld) begin
            mstatus = ld_mst;
            mie     = ld_mie;
            mtvec   = ld_mtvec;
        end else if (bus.we)
            case (bus.addr)
                CSR_MSTATUS: mstatus = bus.wdata;
                CSR_MIE:     mie = bus.wdata;
                CSR_MTVEC:   mtvec = bus.wdata;
                CSR_MEPC:    mepc = bus.wdata;
                CSR_MCAUSE:  mcause = bus.wdata;
                default:     ;
            endcase
    end
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask
    always @(posedge clk_i) begin
        exp_t e;
        cyc++;
        #1;
        if (!rst_i) begin
            if (bus.we) wr_cnt++;
            if (bus.re) begin
                if (bus.addr == CSR_MSTATUS) rd300++;
                else rdoth++;
            end
            if (rv) begin
                redir_cnt++;
                chk("redir_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("redir_pc", rpc, e.pc);
                    if (e.cyc >= 0) chk("redir_cyc", cyc, e.cyc);
                end
            end
        end
    end
    task automatic step(input int n);
        repeat (n) @(posedge clk_i);
        #2;
    endtask
    task automatic setup(input logic [31:0] s, input logic [31:0] m, input logic [31:0] t);
        ld_mst = s;
        ld_mie = m;
        ld_mtvec = t;
        ld = 1'b1;
        @(negedge clk_i);
        #1 ld = 1'b0;
    endtask
    task automatic wait_idle(input string tag);
        for (int k = 0; k < 40 && busy; k++) step(1);
        chk(tag, 32'(busy), 32'd0);
    endtask
    task automatic trap(input logic e, input logic t, input logic [31:0] pcv, input logic [31:0] tgt);
        int r0;
        r0 = redir_cnt;
        pc = pcv;
        ext = e;
        tmr = t;
        step(2);
        chk("wait_stall", 32'(stall), 32'd1);
        chk("wait_intr", 32'(bus.intr), 32'd0);
        ack = 1'b1;
        sb.push_back('{tgt, cyc + 7});
        step(1);
        ack = 1'b0;
        ext = 1'b0;
        tmr = 1'b0;
        step(2);
        chk("wr_intr", 32'(bus.intr), 32'd1);
        wait_idle("trap_idle");
        chk("trap_redir_cnt", 32'(redir_cnt - r0), 32'd1);
    endtask
    initial begin
        int w0, r0, o0, c0;
        logic [31:0] vec_exp;
        step(2);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_redir", 32'(rv), 32'd0);
        chk("rst_csr", {bus.we, bus.re, bus.intr, bus.addr}, 32'd0);
        rst_i = 1'b0;
        // trap entry: ext irq, direct mtvec
        setup(32'h8, 32'h800, 32'h100);
        w0 = wr_cnt;
        trap(1'b1, 1'b0, 32'h40, 32'h100);
        chk("t1_mepc", mepc, 32'h40);
        chk("t1_mcause", mcause, CAUSE_EXT);
        chk("t1_mstatus", mstatus, 32'h80);
        chk("t1_writes", 32'(wr_cnt - w0), 32'd3);
        // MIE clear: single mstatus read then back to idle
        setup(32'h0, 32'h80, 32'h100);
        w0 = wr_cnt; r0 = rd300; o0 = rdoth; c0 = redir_cnt;
        tmr = 1'b1;
        step(2);
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        tmr = 1'b0;
        step(1);
        chk("t2_stall", 32'(stall), 32'd0);
        chk("t2_busy", 32'(busy), 32'd0);
        chk("t2_rd300", 32'(rd300 - r0), 32'd1);
        chk("t2_rdoth", 32'(rdoth - o0), 32'd0);
        chk("t2_writes", 32'(wr_cnt - w0), 32'd0);
        chk("t2_redir", 32'(redir_cnt - c0), 32'd0);
        // both irqs: ext wins, then mret, then tmr
        setup(32'h8, 32'h880, 32'h200);
        trap(1'b1, 1'b1, 32'h80, 32'h200);
        chk("t3_mcause_ext", mcause, CAUSE_EXT);
        mret = 1'b1;
        sb.push_back('{32'h80, cyc + 4});
        step(1);
        mret = 1'b0;
        wait_idle("mret_idle");
        chk("t4_mstatus", mstatus, 32'h88);
        trap(1'b0, 1'b1, 32'h90, 32'h200);
        chk("t3_mcause_tmr", mcause, CAUSE_TMR);
        chk("t3_mepc", mepc, 32'h90);
        chk("t3_mstatus", mstatus, 32'h80);
        // abort in WAIT_ACK
        setup(32'h8, 32'h800, 32'h100);
        w0 = wr_cnt; r0 = rd300; o0 = rdoth;
        ext = 1'b1;
        step(3);
        chk("t5_wait_stall", 32'(stall), 32'd1);
        ext = 1'b0;
        step(2);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_writes", 32'(wr_cnt - w0), 32'd0);
        chk("t5_reads", 32'((rd300 - r0) + (rdoth - o0)), 32'd0);
        // async reset while in WR_MCAUSE
        pc = 32'h44;
        ext = 1'b1;
        step(2);
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        step(3);
        chk("t5_in_wr_mcause", {bus.we, 19'd0, bus.addr}, {1'b1, 19'd0, CSR_MCAUSE});
        rst_i = 1'b1;
        #1;
        chk("t5_rst_csr", {bus.we, bus.re, bus.intr, bus.addr}, 32'd0);
        chk("t5_rst_wdata", bus.wdata, 32'd0);
        chk("t5_rst_flags", {stall, busy, rv}, 32'd0);
        chk("t5_rst_rpc", rpc, 32'd0);
        ext = 1'b0;
        step(2);
        rst_i = 1'b0;
        chk("t5_mcause_kept", mcause, CAUSE_TMR);
        step(1);
        chk("t5_post_busy", 32'(busy), 32'd0);
        // vectored mtvec
`ifdef CSR_TRAP_VECTORED_EN
        vec_exp = 32'h12C;
`else
        vec_exp = 32'h100;
`endif
        setup(32'h8, 32'h800, 32'h101);
        trap(1'b1, 1'b0, 32'h48, vec_exp);
        chk("t6_mepc", mepc, 32'h48);
        step(2);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
